cache_req_arbiter: RTL and testbench
====================================

# cache_req_arbiter

Two-requester round-robin arbiter and sequencer in front of the direct-mapped cache top (`main`). Accepts independent read/write requests from port 0 and port 1 (instruction/data style). Issues one request at a time to the cache's `valid_req`/`rw`/`addr`/`dataIn` interface, waits for completion, and returns `dataOut`/`hit`/`miss` to the owning requester. A watchdog aborts a request the cache never completes.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `TIMEOUT_CYCLES`, default 64: WAIT-state cycles before abort; legal range 2..255.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `reqN_valid` in 1 (N=0,1): request present.
- `reqN_rw` in 1: 1 = read, 0 = write.
- `reqN_addr` in AW: byte address.
- `reqN_wdata` in DW: write data.
- `reqN_ready` out 1: request accepted this cycle when `reqN_valid && reqN_ready`.
- `respN_valid` out 1: one-cycle response pulse.
- `respN_rdata` out DW: read data; 0 for writes and timeouts.
- `respN_hit`, `respN_miss`, `respN_err` out 1 each: cache hit/miss status; `respN_err` flags timeout. All are valid only with `respN_valid`.
- `valid_req` out 1: issue strobe to cache.
- `rw` out 1, `addr` out AW, `dataIn` out DW: to cache.
- `cache_ready` in 1: completion strobe from cache; `dataOut`, `hit`, `miss` are valid in the same cycle.
- `dataOut` in DW, `hit` in 1, `miss` in 1: from cache.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Choose a winner: if only one valid, that port; if both valid, the port ≠ `last_grant`.
  - Assert the winner's `reqN_ready` combinationally. The loser's ready stays 0.
  - On acceptance: latch rw/addr/wdata and owner; set `last_grant`=owner; go to ISSUE.
- ISSUE: `valid_req`=1 for exactly one cycle; go to WAIT; clear the watchdog counter.
- WAIT:
  - `rw`/`addr`/`dataIn` stay held at the latched values.
  - If `cache_ready`=1: capture `dataOut` (reads only, else 0), `hit`, `miss`; err=0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without `cache_ready`: rdata=0, hit=miss=0, err=1; go to RESP.
- RESP: `respN_valid`=1 for the owner only, with the captured fields; go to IDLE.
- `reqN_ready`=0 in every state except IDLE. Requests stay pending and are never dropped.
- `cache_ready` outside WAIT is ignored, including a late completion after a timeout.
- `hit` and `miss` are passed through unmodified. The arbiter does not check that they are mutually exclusive.

## Timing
- Reset values:
  - state IDLE, `last_grant`=1, so port 0 wins the first contention.
  - `valid_req`=0, `rw`=1, `addr`=0, `dataIn`=0.
  - All `respN_*`=0, counter=0.
- Acceptance in cycle t → `valid_req` high in t+1 → WAIT from t+2.
- If `cache_ready` is sampled in cycle k, `respN_valid` is high in k+1 and IDLE is entered in k+2.
- Minimum accept-to-response latency is 3 cycles (`cache_ready` in t+2, response in t+3).
- Back-to-back throughput: one request per (latency+1) cycles; the next acceptance happens in the IDLE cycle after RESP.
- Simultaneous `valid` on both ports in IDLE: exactly one ready. Under continuous contention grants alternate 0,1,0,1.
- A requester may change its `valid`/fields freely until accepted; fields are sampled only at the acceptance edge.
- Reset asserted mid-transaction: the FSM returns to IDLE asynchronously, `valid_req` drops the same instant, and no response is produced for the aborted request.
- Watchdog counter is 8 bits. The timeout response appears TIMEOUT_CYCLES+1 cycles after ISSUE.

## Configuration
- `CACHE_ARB_STATS_EN` defined adds these outputs:
  - `hit_cnt0`, `miss_cnt0`, `hit_cnt1`, `miss_cnt1`: 16 bits each.
  - `timeout_cnt`: 8 bits.
- Counter behaviour when enabled:
  - Incremented in the RESP cycle for the owner according to the captured hit/miss/err.
  - Saturate at all-ones.
  - Cleared only by `reset`.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Port 0 read addr 0x20, cache returns `cache_ready` with `dataOut`=0xDEADBEEF, miss=1, 5 cycles after ISSUE → `resp0_valid` one cycle with rdata 0xDEADBEEF, miss=1, err=0. Port 1 sees no response.
- Both ports valid in the same IDLE cycle (port 0 read 0x40, port 1 write 0x20 data 0x12345678) → port 0 accepted first. Then port 1: the cache sees addr 0x20, rw=0, `dataIn`=0x12345678, and `resp1_rdata`=0.
- Both ports held valid for 6 transactions → grant order 0,1,0,1,0,1. `valid_req` is exactly one cycle per transaction.
- Cache never asserts `cache_ready`, TIMEOUT_CYCLES=8 → `resp0_err`=1, rdata=0, 9 cycles after ISSUE. A `cache_ready` arriving afterwards produces no response.
- `reset` pulsed 2 cycles after ISSUE → `valid_req`=0 and state IDLE immediately; no `respN_valid` follows. A fresh request afterwards completes normally.
- With `CACHE_ARB_STATS_EN`: port 1 gets 3 hits and 1 miss → `hit_cnt1`=3, `miss_cnt1`=1, port-0 counters 0.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - two-port round-robin request sequencer in front of the direct-mapped cache
// Optional CACHE_ARB_STATS_EN adds per-port hit/miss and timeout counters.
module cache_req_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req0_rw,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic          req1_rw,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          resp0_valid,
    output logic [DW-1:0] resp0_rdata,
    output logic          resp0_hit,
    output logic          resp0_miss,
    output logic          resp0_err,
    output logic          resp1_valid,
    output logic [DW-1:0] resp1_rdata,
    output logic          resp1_hit,
    output logic          resp1_miss,
    output logic          resp1_err,
    output logic          valid_req,
    output logic          rw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] dataIn,
    input  logic          cache_ready,
    input  logic [DW-1:0] dataOut,
    input  logic          hit,
    input  logic          miss
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [15:0]   hit_cnt0,
    output logic [15:0]   miss_cnt0,
    output logic [15:0]   hit_cnt1,
    output logic [15:0]   miss_cnt1,
    output logic [7:0]    timeout_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          last_grant;
    logic          owner;
    logic [7:0]    wd_cnt;
    logic [DW-1:0] rdata_q;
    logic          hit_q;
    logic          miss_q;
    logic          err_q;

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            S_IDLE: begin
                // On contention the port that did not win last time goes next.
                if (req0_valid && (!req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (cache_ready || (wd_cnt == WD_LAST)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign valid_req  = (state == S_ISSUE);

    assign resp0_valid = (state == S_RESP) && !owner;
    assign resp1_valid = (state == S_RESP) && owner;
    assign resp0_rdata = resp0_valid ? rdata_q : '0;
    assign resp1_rdata = resp1_valid ? rdata_q : '0;
    assign resp0_hit   = resp0_valid & hit_q;
    assign resp1_hit   = resp1_valid & hit_q;
    assign resp0_miss  = resp0_valid & miss_q;
    assign resp1_miss  = resp1_valid & miss_q;
    assign resp0_err   = resp0_valid & err_q;
    assign resp1_err   = resp1_valid & err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rw         <= 1'b1;
            addr       <= '0;
            dataIn     <= '0;
            wd_cnt     <= 8'd0;
            rdata_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        rw         <= grant1 ? req1_rw    : req0_rw;
                        addr       <= grant1 ? req1_addr  : req0_addr;
                        dataIn     <= grant1 ? req1_wdata : req0_wdata;
                    end
                end
                S_ISSUE: wd_cnt <= 8'd0;
                S_WAIT: begin
                    // A completion in the last watchdog cycle still counts as success.
                    if (cache_ready) begin
                        rdata_q <= rw ? dataOut : '0;
                        hit_q   <= hit;
                        miss_q  <= miss;
                        err_q   <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        rdata_q <= '0;
                        hit_q   <= 1'b0;
                        miss_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt0    <= 16'd0;
            miss_cnt0   <= 16'd0;
            hit_cnt1    <= 16'd0;
            miss_cnt1   <= 16'd0;
            timeout_cnt <= 8'd0;
        end else if (state == S_RESP) begin
            if (err_q) begin
                if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end else begin
                if (hit_q && !owner && (hit_cnt0 != 16'hFFFF))  hit_cnt0  <= hit_cnt0 + 16'd1;
                if (hit_q && owner && (hit_cnt1 != 16'hFFFF))   hit_cnt1  <= hit_cnt1 + 16'd1;
                if (miss_q && !owner && (miss_cnt0 != 16'hFFFF)) miss_cnt0 <= miss_cnt0 + 16'd1;
                if (miss_q && owner && (miss_cnt1 != 16'hFFFF))  miss_cnt1 <= miss_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - randomized scoreboard bench for cache_req_arbiter
module tb_cache_req_arbiter;
    localparam int T = 8;

    typedef struct {
        logic        port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } issue_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        hit;
        logic        miss;
        logic        err;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rv = 2'b00, rrw = 2'b00, rdy;
    logic [31:0] raddr [2];
    logic [31:0] rwd [2];
    logic [1:0]  rsp_v, rsp_hit, rsp_miss, rsp_err;
    logic [31:0] rsp_rdata [2];
    logic        valid_req, rw;
    logic [31:0] addr, dataIn;
    logic        cache_ready = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [31:0] dataOut = 32'h0;
`ifdef CACHE_ARB_STATS_EN
    logic [15:0] hc0, mc0, hc1, mc1;
    logic [7:0]  toc;
`endif

    int checks = 0, failures = 0;
    int cyc = 0;
    issue_t iq[$];
    resp_t  rq[$];
    issue_t cur;
    int     free_cyc = 0, tgt = -1;
    logic   last = 1'b1;
    logic [1:0]  acc = 2'b00;
    logic [31:0] cdata = 32'h0;
    logic [1:0]  chm = 2'b00;
    logic   gen_en = 1'b0, no_complete = 1'b0, armed = 1'b0;
    int     ehit [2], emiss [2], eto;

    cache_req_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(rv[0]), .req0_rw(rrw[0]), .req0_addr(raddr[0]), .req0_wdata(rwd[0]), .req0_ready(rdy[0]),
        .req1_valid(rv[1]), .req1_rw(rrw[1]), .req1_addr(raddr[1]), .req1_wdata(rwd[1]), .req1_ready(rdy[1]),
        .resp0_valid(rsp_v[0]), .resp0_rdata(rsp_rdata[0]), .resp0_hit(rsp_hit[0]),
        .resp0_miss(rsp_miss[0]), .resp0_err(rsp_err[0]),
        .resp1_valid(rsp_v[1]), .resp1_rdata(rsp_rdata[1]), .resp1_hit(rsp_hit[1]),
        .resp1_miss(rsp_miss[1]), .resp1_err(rsp_err[1]),
        .valid_req(valid_req), .rw(rw), .addr(addr), .dataIn(dataIn),
        .cache_ready(cache_ready), .dataOut(dataOut), .hit(hit), .miss(miss)
`ifdef CACHE_ARB_STATS_EN
        , .hit_cnt0(hc0), .miss_cnt0(mc0), .hit_cnt1(hc1), .miss_cnt1(mc1), .timeout_cnt(toc)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Requesters: hold a request until accepted, occasionally rewriting it beforehand.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acc[p]) begin
                rv[p] = 1'b0;
            end else if (rv[p] && $urandom_range(0, 7) == 0) begin
                rv[p]    = 1'($urandom_range(0, 1));
                rrw[p]   = 1'($urandom_range(0, 1));
                raddr[p] = $urandom;
                rwd[p]   = $urandom;
            end
            if (!rv[p] && gen_en && $urandom_range(0, 3) != 0) begin
                rv[p]    = 1'b1;
                rrw[p]   = 1'($urandom_range(0, 1));
                raddr[p] = $urandom;
                rwd[p]   = $urandom;
            end
        end
    end

    // Cache model: completes on the cycle chosen when the request was issued.
    always @(posedge clk) begin
        #1;
        if (tgt >= 0 && cyc == tgt) begin
            cache_ready = 1'b1;
            dataOut     = cdata;
            {hit, miss} = chm;
        end else begin
            cache_ready = 1'b0;
            dataOut     = $urandom;
            {hit, miss} = 2'($urandom_range(0, 3));
        end
    end

    // Arbitration and issue checking; plans the cache reply and expected response.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       p;
        int         r, j;
        acc = 2'b00;
        if (reset) begin
            iq.delete();
            rq.delete();
            free_cyc = cyc;
            last = 1'b1;
            tgt = -1;
            ehit[0] = 0; ehit[1] = 0; emiss[0] = 0; emiss[1] = 0; eto = 0;
        end else begin
            exp_rdy = 2'b00;
            if (cyc > free_cyc) begin
                if (rv[0] && (!rv[1] || last)) exp_rdy = 2'b01;
                else if (rv[1])                exp_rdy = 2'b10;
            end
            chk("ready", 96'(rdy), 96'(exp_rdy));
            if (exp_rdy != 2'b00) begin
                p = exp_rdy[1];
                iq.push_back('{p, rrw[p], raddr[p], rwd[p], cyc});
                last = p;
                free_cyc = 32'h3FFF_FFFF;
                acc[p] = 1'b1;
            end
            if (valid_req) begin
                if (iq.size() == 0) begin
                    chk("valid_req_spurious", 96'(1), 96'(0));
                end else begin
                    cur = iq.pop_front();
                    chk("issue_cycle", 96'(cyc), 96'(cur.cyc + 1));
                    chk("issue_fields", {rw, addr, dataIn}, {cur.rw, cur.addr, cur.wdata});
                    if (no_complete) begin
                        tgt = -1;
                        armed = 1'b1;
                    end else begin
                        r = $urandom_range(0, 9);
                        if (r < 7)       j = $urandom_range(1, 6);
                        else if (r == 7) j = T;
                        else if (r == 8) j = T + 2;
                        else             j = -1;
                        cdata = $urandom;
                        chm   = 2'($urandom_range(0, 3));
                        if (j >= 1 && j <= T) begin
                            tgt = cyc + j;
                            rq.push_back('{cur.port, cur.rw ? cdata : 32'h0, chm[1], chm[0], 1'b0, cyc + j + 1});
                            free_cyc = cyc + j + 1;
                        end else begin
                            tgt = (j > 0) ? cyc + j : -1;
                            rq.push_back('{cur.port, 32'h0, 1'b0, 1'b0, 1'b1, cyc + T + 1});
                            free_cyc = cyc + T + 1;
                        end
                    end
                end
            end else if (iq.size() > 0 && cyc > iq[0].cyc + 1) begin
                chk("issue_missing", 96'(0), 96'(1));
                void'(iq.pop_front());
            end
            if (cache_ready) begin
                chk("held_fields", {rw, addr, dataIn}, {cur.rw, cur.addr, cur.wdata});
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        resp_t e;
        logic  p;
        if (!reset) begin
            if (rsp_v != 2'b00) begin
                if (rsp_v == 2'b11) chk("resp_both", 96'(rsp_v), 96'(1));
                if (rq.size() == 0) begin
                    chk("resp_unexpected", 96'(rsp_v), 96'(0));
                end else begin
                    e = rq.pop_front();
                    p = rsp_v[1];
                    chk("resp_cycle", 96'(cyc), 96'(e.cyc));
                    chk("resp_fields", {p, rsp_err[p], rsp_hit[p], rsp_miss[p], rsp_rdata[p]},
                        {e.port, e.err, e.hit, e.miss, e.rdata});
                    if (e.err) eto++;
                    else begin
                        if (e.hit)  ehit[e.port]++;
                        if (e.miss) emiss[e.port]++;
                    end
                end
            end else if (rq.size() > 0 && cyc > rq[0].cyc) begin
                chk("resp_missing", 96'(0), 96'(1));
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        raddr[0] = 32'h0; raddr[1] = 32'h0; rwd[0] = 32'h0; rwd[1] = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_valid_req", 96'(valid_req), 96'(0));
        chk("reset_cache_fields", {rw, addr, dataIn}, {1'b1, 32'h0, 32'h0});
        chk("reset_resp_valid", 96'(rsp_v), 96'(0));
        chk("reset_resp_fields", {rsp_hit, rsp_miss, rsp_err, rsp_rdata[0], rsp_rdata[1]}, 96'(0));
        chk("reset_ready", 96'(rdy), 96'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        gen_en = 1'b1;
        repeat (3000) @(posedge clk);

        no_complete = 1'b1;
        armed = 1'b0;
        for (int i = 0; i < 200 && !armed; i++) @(negedge clk);
        chk("reset_issue_seen", 96'(armed), 96'(1));
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_valid_req", 96'(valid_req), 96'(0));
        chk("async_reset_fields", {rw, addr, dataIn}, {1'b1, 32'h0, 32'h0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        no_complete = 1'b0;
        repeat (1000) @(posedge clk);

        gen_en = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rv == 2'b00 && iq.size() == 0 && rq.size() == 0) break;
        end
        chk("drain_outstanding", 96'(rq.size() + iq.size() + int'(rv)), 96'(0));
`ifdef CACHE_ARB_STATS_EN
        chk("hit_cnt0", 96'(hc0), 96'(ehit[0]));
        chk("miss_cnt0", 96'(mc0), 96'(emiss[0]));
        chk("hit_cnt1", 96'(hc1), 96'(ehit[1]));
        chk("miss_cnt1", 96'(mc1), 96'(emiss[1]));
        chk("timeout_cnt", 96'(toc), 96'(eto));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
